// File: rtl/wb_regfile_pkg.sv
// Shared constants and decode helpers for the writeback stage and register file.
package wb_regfile_pkg;

    localparam logic [5:0] OP_RTYPE   = 6'b000000;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_LH      = 6'b100001;
    localparam logic [5:0] OP_LBU     = 6'b100100;
    localparam logic [5:0] OP_LHU     = 6'b100101;
    localparam logic [5:0] FUNCT_JALR = 6'b001001;

    localparam logic [4:0]  REG_RA         = 5'd31;
    localparam logic [31:0] PC_LINK_OFFSET = 32'd8;

    typedef enum logic [1:0] {
        SRC_ALU,
        SRC_MEM,
        SRC_LINK
    } wb_src_e;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LB) || (op == OP_LH) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

endpackage

// File: rtl/wb_regfile_sel.sv
// Writeback decode: destination register, writeback data source and effective write enable.
module wb_sel
    import wb_regfile_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic [DW-1:0] pc,
    input  logic [31:0]   instr,
    input  logic [DW-1:0] mem_data,
    input  logic [DW-1:0] alu_result,
    input  logic          reg_we,
    output logic [4:0]    dest,
    output logic [DW-1:0] data,
    output logic          wen
);

    logic [5:0] op;
    logic [5:0] funct;
    wb_src_e    src;
    logic       unused_fields;

    assign op    = instr[31:26];
    assign funct = instr[5:0];
    assign unused_fields = ^{instr[25:21], instr[10:6]};

    always_comb begin
        src  = SRC_ALU;
        dest = instr[20:16];
        if (op == OP_JAL) begin
            dest = REG_RA;
            src  = SRC_LINK;
        end else if (op == OP_RTYPE) begin
            dest = instr[15:11];
            if (funct == FUNCT_JALR) begin
                src = SRC_LINK;
            end
        end else if (is_load(op)) begin
            src = SRC_MEM;
        end
    end

    always_comb begin
        data = alu_result;
        case (src)
            SRC_MEM:  data = mem_data;
            SRC_LINK: data = pc + DW'(PC_LINK_OFFSET);
            default:  data = alu_result;
        endcase
    end

    assign wen = reg_we && (dest != '0);

endmodule

// File: rtl/wb_regfile.sv
// General register file with W-stage writeback, same-cycle W-to-D bypass and a registered commit record.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int unsigned NREG = 32,
    parameter int unsigned DW   = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] w_pc,
    input  logic [31:0]   w_instr,
    input  logic [DW-1:0] w_mem_data,
    input  logic [DW-1:0] w_alu_result,
    input  logic          w_reg_we,
    input  logic [4:0]    rs_addr,
    input  logic [4:0]    rt_addr,
    output logic [DW-1:0] rs_data,
    output logic [DW-1:0] rt_data,
    output logic [4:0]    fwd_addr,
    output logic [DW-1:0] fwd_data,
    output logic          commit_valid,
    output logic [DW-1:0] commit_pc,
    output logic [4:0]    commit_addr,
    output logic [DW-1:0] commit_data
);

    logic [DW-1:0] regs [NREG];
    logic [4:0]    dest;
    logic [DW-1:0] data;
    logic          wen;

    wb_sel #(.DW(DW)) u_sel (
        .pc         (w_pc),
        .instr      (w_instr),
        .mem_data   (w_mem_data),
        .alu_result (w_alu_result),
        .reg_we     (w_reg_we),
        .dest       (dest),
        .data       (data),
        .wen        (wen)
    );

    assign fwd_addr = wen ? dest : '0;
    assign fwd_data = data;

    // Bypass the in-flight write so D sees it in the same cycle; entry 0 is never read.
    always_comb begin
        rs_data = '0;
        if (rs_addr != '0) begin
            rs_data = (wen && rs_addr == dest) ? data : regs[rs_addr];
        end
    end

    always_comb begin
        rt_data = '0;
        if (rt_addr != '0) begin
            rt_data = (wen && rt_addr == dest) ? data : regs[rt_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            commit_valid <= 1'b0;
            commit_pc    <= '0;
            commit_addr  <= '0;
            commit_data  <= '0;
        end else begin
            commit_valid <= wen;
            if (wen) begin
                regs[dest]  <= data;
                commit_pc   <= w_pc;
                commit_addr <= dest;
                commit_data <= data;
            end
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: decode, data select, bypass, commit record and reset.
module tb_wb_regfile;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk;
    logic        reset;
    logic [31:0] w_pc;
    logic [31:0] w_instr;
    logic [31:0] w_mem_data;
    logic [31:0] w_alu_result;
    logic        w_reg_we;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [4:0]  commit_addr;
    logic [31:0] commit_data;

    int checks;
    int errors;

    wb_regfile #(.NREG(32), .DW(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .w_pc         (w_pc),
        .w_instr      (w_instr),
        .w_mem_data   (w_mem_data),
        .w_alu_result (w_alu_result),
        .w_reg_we     (w_reg_we),
        .rs_addr      (rs_addr),
        .rt_addr      (rt_addr),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .fwd_addr     (fwd_addr),
        .fwd_data     (fwd_data),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_addr  (commit_addr),
        .commit_data  (commit_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle just after it before driving or sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        w_reg_we     = 1'b0;
        w_instr      = 32'h0;
        w_mem_data   = 32'h0;
        w_alu_result = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        w_pc = RESET_PC;
        idle();
        rs_addr = 5'd5;
        rt_addr = 5'd31;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (rs_data !== 32'h0) begin errors++; $display("FAIL reset_rs got %h exp %h", rs_data, 32'h0); end
        checks++;
        if (rt_data !== 32'h0) begin errors++; $display("FAIL reset_rt got %h exp %h", rt_data, 32'h0); end
        checks++;
        if (commit_valid !== 1'b0) begin errors++; $display("FAIL reset_cv got %b exp 0", commit_valid); end
        checks++;
        if (commit_pc !== 32'h0) begin errors++; $display("FAIL reset_cpc got %h exp 0", commit_pc); end
    endtask

    task automatic test_load_bypass();
        w_pc         = RESET_PC;
        w_instr      = {6'b100011, 5'd2, 5'd8, 16'h0010};
        w_reg_we     = 1'b1;
        w_mem_data   = 32'hDEAD_BEEF;
        w_alu_result = 32'h0000_1234;
        rs_addr      = 5'd8;
        #1;
        checks++;
        if (fwd_addr !== 5'd8) begin errors++; $display("FAIL lw_fwd_addr got %0d exp 8", fwd_addr); end
        checks++;
        if (fwd_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_fwd_data got %h exp deadbeef", fwd_data); end
        checks++;
        if (rs_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_bypass got %h exp deadbeef", rs_data); end
        tick();
        idle();
        #1;
        checks++;
        if (commit_valid !== 1'b1) begin errors++; $display("FAIL lw_cv got %b exp 1", commit_valid); end
        checks++;
        if (commit_addr !== 5'd8) begin errors++; $display("FAIL lw_caddr got %0d exp 8", commit_addr); end
        checks++;
        if (commit_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_cdata got %h exp deadbeef", commit_data); end
        checks++;
        if (commit_pc !== RESET_PC) begin errors++; $display("FAIL lw_cpc got %h exp %h", commit_pc, RESET_PC); end
        checks++;
        if (rs_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_stored got %h exp deadbeef", rs_data); end
    endtask

    task automatic test_all_loads();
        logic [5:0] ops [5];
        ops[0] = 6'b100011; ops[1] = 6'b100000; ops[2] = 6'b100001;
        ops[3] = 6'b100100; ops[4] = 6'b100101;
        for (int i = 0; i < 5; i++) begin
            w_instr      = {ops[i], 5'd0, 5'(12 + i), 16'h0};
            w_reg_we     = 1'b1;
            w_mem_data   = 32'h5500_0000 + 32'(i);
            w_alu_result = 32'h0000_0AA0;
            #1;
            checks++;
            if (fwd_data !== 32'h5500_0000 + 32'(i)) begin
                errors++; $display("FAIL load_sel op=%b got %h exp %h", ops[i], fwd_data, 32'h5500_0000 + 32'(i));
            end
            tick();
        end
        // A non-load I-type must select the ALU result.
        w_instr = {6'b001001, 5'd0, 5'd17, 16'h0};
        #1;
        checks++;
        if (fwd_data !== 32'h0000_0AA0) begin errors++; $display("FAIL addiu_sel got %h exp 00000aa0", fwd_data); end
        tick();
        idle();
    endtask

    task automatic test_jal();
        w_pc     = 32'h0000_3004;
        w_instr  = {6'b000011, 26'h0000C01};
        w_reg_we = 1'b1;
        w_alu_result = 32'h0000_0077;
        #1;
        checks++;
        if (fwd_addr !== 5'd31) begin errors++; $display("FAIL jal_fwd_addr got %0d exp 31", fwd_addr); end
        checks++;
        if (fwd_data !== 32'h0000_300C) begin errors++; $display("FAIL jal_fwd_data got %h exp 0000300c", fwd_data); end
        tick();
        idle();
        rt_addr = 5'd31;
        #1;
        checks++;
        if (rt_data !== 32'h0000_300C) begin errors++; $display("FAIL jal_reg31 got %h exp 0000300c", rt_data); end
        checks++;
        if (commit_pc !== 32'h0000_3004) begin errors++; $display("FAIL jal_cpc got %h exp 00003004", commit_pc); end
    endtask

    task automatic test_jalr_rd0();
        w_pc     = 32'h0000_3010;
        w_instr  = {6'b000000, 5'd31, 5'd0, 5'd0, 5'd0, 6'b001001};
        w_reg_we = 1'b1;
        #1;
        checks++;
        if (fwd_addr !== 5'd0) begin errors++; $display("FAIL jalr0_fwd_addr got %0d exp 0", fwd_addr); end
        checks++;
        if (fwd_data !== 32'h0000_3018) begin errors++; $display("FAIL jalr0_fwd_data got %h exp 00003018", fwd_data); end
        tick();
        idle();
        #1;
        checks++;
        if (commit_valid !== 1'b0) begin errors++; $display("FAIL jalr0_cv got %b exp 0", commit_valid); end
        checks++;
        if (commit_addr !== 5'd31) begin errors++; $display("FAIL jalr0_hold_addr got %0d exp 31", commit_addr); end
        checks++;
        if (commit_data !== 32'h0000_300C) begin errors++; $display("FAIL jalr0_hold_data got %h exp 0000300c", commit_data); end
    endtask

    task automatic test_no_we();
        w_instr      = {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100001};
        w_alu_result = 32'h0000_0011;
        w_reg_we     = 1'b1;
        tick();
        w_alu_result = 32'h0000_0007;
        w_reg_we     = 1'b0;
        rt_addr      = 5'd3;
        #1;
        checks++;
        if (fwd_addr !== 5'd0) begin errors++; $display("FAIL nowe_fwd_addr got %0d exp 0", fwd_addr); end
        checks++;
        if (rt_data !== 32'h0000_0011) begin errors++; $display("FAIL nowe_rt_now got %h exp 00000011", rt_data); end
        tick();
        idle();
        #1;
        checks++;
        if (rt_data !== 32'h0000_0011) begin errors++; $display("FAIL nowe_rt_after got %h exp 00000011", rt_data); end
        checks++;
        if (commit_valid !== 1'b0) begin errors++; $display("FAIL nowe_cv got %b exp 0", commit_valid); end
    endtask

    task automatic test_write_zero();
        w_instr      = {6'b001001, 5'd1, 5'd0, 16'h0005};
        w_alu_result = 32'h0000_0005;
        w_reg_we     = 1'b1;
        rs_addr      = 5'd0;
        #1;
        checks++;
        if (rs_data !== 32'h0) begin errors++; $display("FAIL zero_rs_now got %h exp 0", rs_data); end
        checks++;
        if (fwd_addr !== 5'd0) begin errors++; $display("FAIL zero_fwd_addr got %0d exp 0", fwd_addr); end
        tick();
        idle();
        #1;
        checks++;
        if (rs_data !== 32'h0) begin errors++; $display("FAIL zero_rs_after got %h exp 0", rs_data); end
        checks++;
        if (commit_valid !== 1'b0) begin errors++; $display("FAIL zero_cv got %b exp 0", commit_valid); end
        // All-zero nop with write enable set must not commit either.
        w_instr  = 32'h0;
        w_reg_we = 1'b1;
        tick();
        idle();
        #1;
        checks++;
        if (commit_valid !== 1'b0) begin errors++; $display("FAIL nop_cv got %b exp 0", commit_valid); end
    endtask

    task automatic test_dual_bypass();
        w_instr      = {6'b000000, 5'd4, 5'd5, 5'd10, 5'd0, 6'b100001};
        w_alu_result = 32'h0000_ABCD;
        w_reg_we     = 1'b1;
        rs_addr      = 5'd10;
        rt_addr      = 5'd10;
        #1;
        checks++;
        if (rs_data !== 32'h0000_ABCD) begin errors++; $display("FAIL dual_rs got %h exp 0000abcd", rs_data); end
        checks++;
        if (rt_data !== 32'h0000_ABCD) begin errors++; $display("FAIL dual_rt got %h exp 0000abcd", rt_data); end
        tick();
        // Back-to-back overwrite of the same register: bypass wins over the stored value.
        w_alu_result = 32'h0000_1111;
        #1;
        checks++;
        if (rs_data !== 32'h0000_1111) begin errors++; $display("FAIL b2b_rs got %h exp 00001111", rs_data); end
        tick();
        idle();
        #1;
        checks++;
        if (rt_data !== 32'h0000_1111) begin errors++; $display("FAIL b2b_rt got %h exp 00001111", rt_data); end
    endtask

    task automatic test_wrap();
        w_pc     = 32'hFFFF_FFFC;
        w_instr  = {6'b000011, 26'h0};
        w_reg_we = 1'b1;
        #1;
        checks++;
        if (fwd_data !== 32'h0000_0004) begin errors++; $display("FAIL wrap_fwd got %h exp 00000004", fwd_data); end
        tick();
        idle();
        rs_addr = 5'd31;
        #1;
        checks++;
        if (rs_data !== 32'h0000_0004) begin errors++; $display("FAIL wrap_reg31 got %h exp 00000004", rs_data); end
        checks++;
        if (commit_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_cpc got %h exp fffffffc", commit_pc); end
    endtask

    task automatic test_reset_priority();
        w_pc         = 32'h0000_3100;
        w_instr      = {6'b001001, 5'd0, 5'd4, 16'h0001};
        w_alu_result = 32'h0000_0001;
        w_reg_we     = 1'b1;
        tick();
        idle();
        rs_addr = 5'd4;
        #1;
        checks++;
        if (rs_data !== 32'h0000_0001) begin errors++; $display("FAIL rstp_pre got %h exp 00000001", rs_data); end
        w_instr      = {6'b001001, 5'd0, 5'd4, 16'h0009};
        w_alu_result = 32'h0000_0009;
        w_reg_we     = 1'b1;
        reset        = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        #1;
        checks++;
        if (rs_data !== 32'h0) begin errors++; $display("FAIL rstp_reg4 got %h exp 0", rs_data); end
        checks++;
        if (commit_valid !== 1'b0) begin errors++; $display("FAIL rstp_cv got %b exp 0", commit_valid); end
        checks++;
        if (commit_addr !== 5'd0) begin errors++; $display("FAIL rstp_caddr got %0d exp 0", commit_addr); end
        checks++;
        if (commit_data !== 32'h0) begin errors++; $display("FAIL rstp_cdata got %h exp 0", commit_data); end
        rt_addr = 5'd31;
        #1;
        checks++;
        if (rt_data !== 32'h0) begin errors++; $display("FAIL rstp_reg31 got %h exp 0", rt_data); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_load_bypass();
        test_all_loads();
        test_jal();
        test_jalr_rd0();
        test_no_we();
        test_write_zero();
        test_dual_bypass();
        test_wrap();
        test_reset_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule
